// File: rtl/cs_seq.sv
// Command sequencer: admits one upstream fs/fd request, then walks STAGES downstream
// fs/fd handshakes in order, with FIFO-full admission gating and a per-stage watchdog.
module cs_seq #(
    parameter int STAGES  = 2,
    parameter int NFULL   = 3,
    parameter int TIMEOUT = 1000000,
    parameter int CW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NFULL-1:0]  fifo_full,
    input  logic              fs_in,
    output logic              fd_in,
    output logic [STAGES-1:0] fs_stage,
    input  logic [STAGES-1:0] fd_stage,
    output logic              busy,
    output logic [3:0]        cur_stage,
    output logic              err_timeout,
    output logic [CW-1:0]     led_cont
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [3:0] LAST_STAGE = 4'(STAGES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        stage_q, stage_d;
    logic [WDW-1:0]    wdog_q, wdog_d;
    logic [STAGES-1:0] fs_stage_q, fs_stage_d;
    logic              fd_in_q, fd_in_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [CW-1:0]     led_q, led_d;
    logic              fd_cur, wd_hit;

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        wdog_d     = wdog_q;
        fs_stage_d = fs_stage_q;
        fd_in_d    = fd_in_q;
        err_d      = err_q;
        led_d      = led_q;
        // Only the active stage's done line matters; the others are masked off.
        fd_cur     = |(fd_stage & (STAGES'(1) << stage_q));
        wd_hit     = (TIMEOUT > 0) && (wdog_q == WD_LAST);

        case (state_q)
            S_IDLE: begin
                if (fs_in && (fifo_full == '0)) begin
                    state_d    = S_REQ;
                    stage_d    = 4'd0;
                    wdog_d     = '0;
                    fs_stage_d = STAGES'(1);
                    err_d      = 1'b0;
                end
            end
            S_REQ: begin
                if (fd_cur) begin
                    state_d    = S_REL;
                    fs_stage_d = '0;
                    wdog_d     = '0;
                end else if (wd_hit) begin
                    state_d    = S_ERR;
                    fs_stage_d = '0;
                    err_d      = 1'b1;
                    fd_in_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_REL: begin
                if (!fd_cur) begin
                    wdog_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_DONE;
                        fd_in_d = 1'b1;
                        led_d   = led_q + CW'(1);
                    end else begin
                        state_d    = S_REQ;
                        stage_d    = stage_q + 4'd1;
                        fs_stage_d = STAGES'(1) << (stage_q + 4'd1);
                    end
                end else if (wd_hit) begin
                    state_d    = S_ERR;
                    fs_stage_d = '0;
                    err_d      = 1'b1;
                    fd_in_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            S_DONE, S_ERR: begin
                if (!fs_in) begin
                    state_d = S_IDLE;
                    fd_in_d = 1'b0;
                    stage_d = 4'd0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                stage_d    = 4'd0;
                fs_stage_d = '0;
                fd_in_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            stage_q    <= 4'd0;
            wdog_q     <= '0;
            fs_stage_q <= '0;
            fd_in_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            wdog_q     <= wdog_d;
            fs_stage_q <= fs_stage_d;
            fd_in_q    <= fd_in_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            led_q      <= led_d;
        end
    end

    assign fs_stage    = fs_stage_q;
    assign fd_in       = fd_in_q;
    assign busy        = busy_q;
    assign cur_stage   = stage_q;
    assign err_timeout = err_q;
    assign led_cont    = led_q;

endmodule

// File: tb/tb_cs_seq.sv
// Bench for cs_seq (STAGES=2, TIMEOUT=16, CW=4): vector tables replayed through a
// scoreboard queue, plus a hand-driven asynchronous reset sequence.
module tb_cs_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] fifo_full;
    logic       fs_in;
    logic       fd_in;
    logic [1:0] fs_stage;
    logic [1:0] fd_stage;
    logic       busy;
    logic [3:0] cur_stage;
    logic       err_timeout;
    logic [3:0] led_cont;

    cs_seq #(.STAGES(2), .NFULL(3), .TIMEOUT(16), .CW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_full   (fifo_full),
        .fs_in       (fs_in),
        .fd_in       (fd_in),
        .fs_stage    (fs_stage),
        .fd_stage    (fd_stage),
        .busy        (busy),
        .cur_stage   (cur_stage),
        .err_timeout (err_timeout),
        .led_cont    (led_cont)
    );

    always #5 clk = ~clk;

    // Observed bundle: {fs_stage, fd_in, busy, cur_stage, err_timeout, led_cont}
    logic [12:0] obs;
    assign obs = {fs_stage, fd_in, busy, cur_stage, err_timeout, led_cont};

    typedef struct {
        logic        fs_in;
        logic [2:0]  full;
        logic [1:0]  fd;
        logic [12:0] exp;
    } vec_t;

    vec_t        tab1[$];
    vec_t        tab2[$];
    logic [12:0] sb[$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [12:0] mk(logic [1:0] fs, logic fdi, logic b,
                                       logic [3:0] cur, logic e, logic [3:0] led);
        return {fs, fdi, b, cur, e, led};
    endfunction

    function automatic void add(int t, logic fsi, logic [2:0] full, logic [1:0] fd,
                                logic [12:0] e);
        vec_t v;
        v.fs_in = fsi;
        v.full  = full;
        v.fd    = fd;
        v.exp   = e;
        if (t == 1) tab1.push_back(v);
        else        tab2.push_back(v);
    endfunction

    // One full command against zero-latency responders, ending back in IDLE.
    function automatic void add_cmd(int t, logic [3:0] led);
        logic [3:0] n;
        n = led + 4'd1;
        add(t, 1, 3'b000, 2'b00, mk(2'b01, 0, 1, 4'd0, 0, led));
        add(t, 1, 3'b000, 2'b01, mk(2'b00, 0, 1, 4'd0, 0, led));
        add(t, 1, 3'b000, 2'b00, mk(2'b10, 0, 1, 4'd1, 0, led));
        add(t, 1, 3'b000, 2'b10, mk(2'b00, 0, 1, 4'd1, 0, led));
        add(t, 1, 3'b000, 2'b00, mk(2'b00, 1, 1, 4'd1, 0, n));
        add(t, 0, 3'b000, 2'b00, mk(2'b00, 0, 0, 4'd0, 0, n));
    endfunction

    task automatic chk(string nm, logic [12:0] act, logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic run_tab(int t, string nm);
        int n;
        vec_t v;
        logic [12:0] e;
        n = (t == 1) ? tab1.size() : tab2.size();
        for (int i = 0; i < n; i++) begin
            v = (t == 1) ? tab1[i] : tab2[i];
            @(negedge clk);
            fs_in     = v.fs_in;
            fifo_full = v.full;
            fd_stage  = v.fd;
            sb.push_back(v.exp);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s[%0d]: scoreboard empty", nm, i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s[%0d]", nm, i), obs, e);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        // Nominal command
        add_cmd(1, 4'd0);
        // Full gating: request held off, then admitted; foreign fd and full ignored mid-command,
        // and upstream dropping fs_in early does not cut the sequence short.
        for (int i = 0; i < 10; i++) add(1, 1, 3'b010, 2'b00, mk(2'b00, 0, 0, 4'd0, 0, 4'd1));
        add(1, 1, 3'b000, 2'b00, mk(2'b01, 0, 1, 4'd0, 0, 4'd1));
        add(1, 1, 3'b111, 2'b10, mk(2'b01, 0, 1, 4'd0, 0, 4'd1));
        add(1, 0, 3'b111, 2'b01, mk(2'b00, 0, 1, 4'd0, 0, 4'd1));
        add(1, 0, 3'b000, 2'b00, mk(2'b10, 0, 1, 4'd1, 0, 4'd1));
        add(1, 0, 3'b000, 2'b10, mk(2'b00, 0, 1, 4'd1, 0, 4'd1));
        add(1, 0, 3'b000, 2'b00, mk(2'b00, 1, 1, 4'd1, 0, 4'd2));
        add(1, 0, 3'b000, 2'b00, mk(2'b00, 0, 0, 4'd0, 0, 4'd2));
        // Timeout in REQ(1): 16 cycles without fd_stage[1]
        add(1, 1, 3'b000, 2'b00, mk(2'b01, 0, 1, 4'd0, 0, 4'd2));
        add(1, 1, 3'b000, 2'b01, mk(2'b00, 0, 1, 4'd0, 0, 4'd2));
        add(1, 1, 3'b000, 2'b00, mk(2'b10, 0, 1, 4'd1, 0, 4'd2));
        for (int i = 0; i < 15; i++) add(1, 1, 3'b000, 2'b00, mk(2'b10, 0, 1, 4'd1, 0, 4'd2));
        add(1, 1, 3'b000, 2'b00, mk(2'b00, 1, 1, 4'd1, 1, 4'd2));
        add(1, 1, 3'b000, 2'b00, mk(2'b00, 1, 1, 4'd1, 1, 4'd2));
        add(1, 0, 3'b000, 2'b00, mk(2'b00, 0, 0, 4'd0, 1, 4'd2));
        add(1, 0, 3'b000, 2'b00, mk(2'b00, 0, 0, 4'd0, 1, 4'd2));
        add_cmd(1, 4'd2);
        // Race: fd_stage[0] arrives on the same edge the watchdog expires
        add(1, 1, 3'b000, 2'b00, mk(2'b01, 0, 1, 4'd0, 0, 4'd3));
        for (int i = 0; i < 15; i++) add(1, 1, 3'b000, 2'b00, mk(2'b01, 0, 1, 4'd0, 0, 4'd3));
        add(1, 1, 3'b000, 2'b01, mk(2'b00, 0, 1, 4'd0, 0, 4'd3));
        add(1, 1, 3'b000, 2'b00, mk(2'b10, 0, 1, 4'd1, 0, 4'd3));
        add(1, 1, 3'b000, 2'b10, mk(2'b00, 0, 1, 4'd1, 0, 4'd3));
        add(1, 1, 3'b000, 2'b00, mk(2'b00, 1, 1, 4'd1, 0, 4'd4));
        add(1, 0, 3'b000, 2'b00, mk(2'b00, 0, 0, 4'd0, 0, 4'd4));
        // Counter wrap after reset: 17 commands, led goes ..., 15, 0, 1
        for (int i = 0; i < 17; i++) add_cmd(2, 4'(i));

        rst       = 1'b0;
        fs_in     = 1'b0;
        fifo_full = 3'b000;
        fd_stage  = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_state", obs, 13'd0);

        run_tab(1, "main");

        // Asynchronous reset while in REL(0)
        @(negedge clk);
        fs_in = 1'b1; fd_stage = 2'b00;
        @(posedge clk); #1;
        chk("rst_seq_req0", obs, mk(2'b01, 0, 1, 4'd0, 0, 4'd4));
        @(negedge clk);
        fd_stage = 2'b01;
        @(posedge clk); #1;
        chk("rst_seq_rel0", obs, mk(2'b00, 0, 1, 4'd0, 0, 4'd4));
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", obs, 13'd0);
        @(negedge clk);
        fs_in = 1'b0; fd_stage = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_idle", obs, 13'd0);

        run_tab(2, "wrap");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cs_seq.md
Name: cs_seq

Overview:
- Parametrised successor to the fixed two-stage command sequencer used for the UDP-rx -> MAC-to-FIFO-C -> FIFO-C-to-CS path.
- Accepts one command request from upstream over a four-phase fs/fd level handshake. It then drives STAGES downstream stages strictly in order, each over its own four-phase fs/fd pair.
- Adds behaviour the fixed version lacks: FIFO-full admission gating, a per-stage watchdog timeout with a sticky error, and a wrapping completed-command counter for LED/status display.

Parameters:
- STAGES, 2, number of downstream stages sequenced per command (1..16).
- NFULL, 3, number of FIFO-full flags that gate admission.
- TIMEOUT, 1000000, maximum cycles spent in any single stage wait; 0 disables the watchdog.
- CW, 32, width of the completion counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- fifo_full  in  NFULL  FIFO-full flags; any bit high blocks admission of a new command.
- fs_in  in  1  upstream start request (level).
- fd_in  out  1  upstream done acknowledge (level).
- fs_stage  out  STAGES  per-stage start; at most one bit high at any time.
- fd_stage  in  STAGES  per-stage done.
- busy  out  1  high whenever the state is not IDLE.
- cur_stage  out  4  index of the active stage; 0 when idle.
- err_timeout  out  1  sticky watchdog error flag.
- led_cont  out  CW  count of successfully completed commands; wraps modulo 2^CW.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - fs_stage, fd_in, busy, cur_stage, err_timeout and led_cont are all 0.
  - Watchdog counter = 0.
  - Reset asserted mid-command aborts the command immediately, with no completion and no error.
- States: IDLE, REQ(k), REL(k), DONE, ERR. Stage index k is held in a register and output on cur_stage.
- IDLE:
  - If fs_in=1 and fifo_full==0 are sampled on an edge: go to REQ(0); fs_stage[0]=1 from the next cycle; err_timeout is cleared.
  - If any full bit is high, stay in IDLE. The request is not lost; it is admitted on the first edge where all full bits are low.
- REQ(k): fs_stage[k] is held high.
  - When fd_stage[k]=1 is sampled: fs_stage[k]=0 next cycle; go to REL(k).
- REL(k): waits for fd_stage[k]=0.
  - If k<STAGES-1: go to REQ(k+1), with fs_stage[k+1] high next cycle.
  - If k=STAGES-1: go to DONE; fd_in=1 next cycle; led_cont increments by 1 (wrapping from all-ones to 0).
- Per-stage latency with an immediate responder: 1 cycle REQ->REL, 1 cycle REL->next REQ.
- fd_stage[j] for j!=k is ignored. fifo_full is only consulted in IDLE.
- DONE: fd_in is held at 1.
  - When fs_in=0 is sampled: fd_in=0 next cycle; go to IDLE.
- Watchdog (TIMEOUT>0):
  - The counter resets to 0 on every entry to REQ(k) or REL(k), and increments each cycle while in that state.
  - When the counter reaches TIMEOUT-1 without the awaited fd edge: go to ERR. All fs_stage bits = 0 and err_timeout = 1 from the next cycle.
  - If the awaited fd level and the timeout occur on the same edge, the fd level wins (no error).
- ERR:
  - fd_in=1, so upstream is never hung; led_cont is not incremented.
  - When fs_in=0 is sampled: fd_in=0; go to IDLE.
  - err_timeout stays set until the next command is admitted.
- Upstream protocol violation: fs_in dropping before fd_in is ignored. The sequence runs to DONE/ERR, then returns to IDLE on the first sample with fs_in=0.
- busy = (state != IDLE), registered. At most one fs_stage bit is ever high.

Test Plan:
- Nominal, STAGES=2, TIMEOUT=16, zero-latency responders:
  - fs_in=1 -> fs_stage=01, then 00, then 10, then 00; fd_in=1 on cycle 5; led_cont=1.
  - fs_in=0 -> fd_in=0 next cycle; busy=0.
- Full gating:
  - fifo_full=3'b010 held 10 cycles with fs_in=1 -> fs_stage stays 0 and busy=0.
  - Clear fifo_full -> fs_stage[0]=1 on the following cycle.
- Timeout:
  - Stage 1 never answers fd_stage[1] -> after 16 cycles in REQ(1): fs_stage=0, err_timeout=1, fd_in=1, led_cont unchanged.
  - Next admitted command clears err_timeout.
- Counter wrap: CW=4, run 17 commands -> led_cont reads 15, then 0, then 1.
- Reset mid-command:
  - Drop rst while in REL(0) -> all outputs 0 asynchronously, state IDLE.
  - After release, a new fs_in starts at stage 0.
- Race: fd_stage[0] rises on the same edge the watchdog reaches TIMEOUT-1 -> REL(0) entered, err_timeout remains 0.
